// File: rtl/traffic_phase_controller.sv
// Two-road traffic phase FSM; outputs registered with the state, so they change on the edge that changes the phase.
// No backpressure: acts only on tmr_expired pulses. Pedestrian walk phase compiled in with PED_REQUEST_EN.
module traffic_phase_controller #(
  parameter int MAX_HOLD = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ns_sensor,
  input  logic       ew_sensor,
  input  logic       tmr_expired,
  output logic       tmr_start,
  output logic       tmr_extend,
  output logic       tmr_yellow,
  output logic [1:0] ns_light,
  output logic [1:0] ew_light,
  output logic [2:0] phase
`ifdef PED_REQUEST_EN
  ,
  input  logic       ped_req,
  output logic       ped_walk
`endif
);

  typedef enum logic [2:0] {
    INIT      = 3'd0,
    NS_GREEN  = 3'd1,
    NS_YELLOW = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4
`ifdef PED_REQUEST_EN
    ,
    PED_WALK  = 3'd5
`endif
  } state_t;

  localparam logic [1:0] LAMP_RED = 2'b00;
  localparam logic [1:0] LAMP_YEL = 2'b01;
  localparam logic [1:0] LAMP_GRN = 2'b10;
  localparam logic [2:0] HOLD_LIMIT = 3'(MAX_HOLD);

  state_t     state;
  state_t     state_nxt;
  logic [2:0] hold_cnt;
  logic [2:0] hold_cnt_nxt;
  logic       green_load;
  logic       ped_pending;
  logic [1:0] ns_light_nxt;
  logic [1:0] ew_light_nxt;
  logic       tmr_yellow_nxt;
  logic       tmr_extend_nxt;

`ifdef PED_REQUEST_EN
  logic ped_latch;
  logic ped_to_ew;
  logic ped_to_ew_nxt;
  logic ped_walk_nxt;

  // A request arriving in the deciding cycle counts as pending too.
  assign ped_pending = ped_latch | ped_req;
`else
  assign ped_pending = 1'b0;
`endif

  always_comb begin
    state_nxt    = state;
    hold_cnt_nxt = hold_cnt;
    green_load   = 1'b0;
`ifdef PED_REQUEST_EN
    ped_to_ew_nxt = ped_to_ew;
`endif
    case (state)
      INIT: begin
        state_nxt  = NS_GREEN;
        green_load = 1'b1;
      end
      NS_GREEN: begin
        if (tmr_expired) begin
          if (!ew_sensor && (hold_cnt < HOLD_LIMIT) && !ped_pending) begin
            green_load = 1'b1;
            if (hold_cnt != 3'd7) hold_cnt_nxt = hold_cnt + 3'd1;
          end else begin
            state_nxt    = NS_YELLOW;
            hold_cnt_nxt = 3'd0;
          end
        end
      end
      NS_YELLOW: begin
        if (tmr_expired) begin
          state_nxt  = EW_GREEN;
          green_load = 1'b1;
`ifdef PED_REQUEST_EN
          if (ped_pending) begin
            state_nxt     = PED_WALK;
            green_load    = 1'b0;
            ped_to_ew_nxt = 1'b1;
          end
`endif
        end
      end
      EW_GREEN: begin
        if (tmr_expired) begin
          if (!ns_sensor && (hold_cnt < HOLD_LIMIT) && !ped_pending) begin
            green_load = 1'b1;
            if (hold_cnt != 3'd7) hold_cnt_nxt = hold_cnt + 3'd1;
          end else begin
            state_nxt    = EW_YELLOW;
            hold_cnt_nxt = 3'd0;
          end
        end
      end
      EW_YELLOW: begin
        if (tmr_expired) begin
          state_nxt  = NS_GREEN;
          green_load = 1'b1;
`ifdef PED_REQUEST_EN
          if (ped_pending) begin
            state_nxt     = PED_WALK;
            green_load    = 1'b0;
            ped_to_ew_nxt = 1'b0;
          end
`endif
        end
      end
`ifdef PED_REQUEST_EN
      PED_WALK: begin
        if (tmr_expired) begin
          state_nxt  = ped_to_ew ? EW_GREEN : NS_GREEN;
          green_load = 1'b1;
        end
      end
`endif
      default: state_nxt = INIT;
    endcase
  end

  // Outputs are decoded from the next state so they register alongside it.
  always_comb begin
    ns_light_nxt   = LAMP_RED;
    ew_light_nxt   = LAMP_RED;
    tmr_yellow_nxt = 1'b0;
    tmr_extend_nxt = 1'b0;
`ifdef PED_REQUEST_EN
    ped_walk_nxt   = 1'b0;
`endif
    case (state_nxt)
      NS_GREEN: begin
        ns_light_nxt   = LAMP_GRN;
        tmr_extend_nxt = green_load ? (ns_sensor & ~ew_sensor) : tmr_extend;
      end
      NS_YELLOW: begin
        ns_light_nxt   = LAMP_YEL;
        tmr_yellow_nxt = 1'b1;
      end
      EW_GREEN: begin
        ew_light_nxt   = LAMP_GRN;
        tmr_extend_nxt = green_load ? (ew_sensor & ~ns_sensor) : tmr_extend;
      end
      EW_YELLOW: begin
        ew_light_nxt   = LAMP_YEL;
        tmr_yellow_nxt = 1'b1;
      end
`ifdef PED_REQUEST_EN
      PED_WALK: ped_walk_nxt = 1'b1;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= INIT;
      hold_cnt   <= 3'd0;
      phase      <= 3'd0;
      ns_light   <= LAMP_RED;
      ew_light   <= LAMP_RED;
      tmr_start  <= 1'b0;
      tmr_extend <= 1'b0;
      tmr_yellow <= 1'b0;
    end else begin
      state      <= state_nxt;
      hold_cnt   <= hold_cnt_nxt;
      phase      <= state_nxt;
      ns_light   <= ns_light_nxt;
      ew_light   <= ew_light_nxt;
      tmr_start  <= (state_nxt != INIT);
      tmr_extend <= tmr_extend_nxt;
      tmr_yellow <= tmr_yellow_nxt;
    end
  end

`ifdef PED_REQUEST_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ped_latch <= 1'b0;
      ped_to_ew <= 1'b0;
      ped_walk  <= 1'b0;
    end else begin
      ped_to_ew <= ped_to_ew_nxt;
      ped_walk  <= ped_walk_nxt;
      if (state_nxt == PED_WALK && state != PED_WALK) ped_latch <= 1'b0;
      else if (ped_req && state != PED_WALK)            ped_latch <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_traffic_phase_controller.sv
// Directed bench for traffic_phase_controller: reset, extend, hold, full cycle, mid-phase reset, pedestrian walk.
module tb_traffic_phase_controller;

  logic       clk;
  logic       rst_n;
  logic       ns_sensor;
  logic       ew_sensor;
  logic       tmr_expired;
  logic       tmr_start;
  logic       tmr_extend;
  logic       tmr_yellow;
  logic [1:0] ns_light;
  logic [1:0] ew_light;
  logic [2:0] phase;
`ifdef PED_REQUEST_EN
  logic       ped_req;
  logic       ped_walk;
`endif

  int checks = 0;
  int errors = 0;

  traffic_phase_controller #(.MAX_HOLD(3)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ns_sensor   (ns_sensor),
    .ew_sensor   (ew_sensor),
    .tmr_expired (tmr_expired),
    .tmr_start   (tmr_start),
    .tmr_extend  (tmr_extend),
    .tmr_yellow  (tmr_yellow),
    .ns_light    (ns_light),
    .ew_light    (ew_light),
    .phase       (phase)
`ifdef PED_REQUEST_EN
    ,
    .ped_req     (ped_req),
    .ped_walk    (ped_walk)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expire();
    tmr_expired = 1'b1;
    tick();
    tmr_expired = 1'b0;
  endtask

  // Reset with given sensor levels, release, and land in NS_GREEN.
  task automatic restart(input logic ns, input logic ew);
    rst_n = 1'b0;
    ns_sensor = ns;
    ew_sensor = ew;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    #3;
    checks++; if (phase !== 3'd0) begin errors++; $display("FAIL reset_phase: got %0d expected 0", phase); end
    checks++; if (ns_light !== 2'b00 || ew_light !== 2'b00) begin errors++; $display("FAIL reset_lamps: got ns=%b ew=%b expected 00/00", ns_light, ew_light); end
    checks++; if (tmr_start !== 1'b0) begin errors++; $display("FAIL reset_start: got %b expected 0", tmr_start); end
    checks++; if (tmr_extend !== 1'b0 || tmr_yellow !== 1'b0) begin errors++; $display("FAIL reset_timer_sel: got ext=%b yel=%b expected 0/0", tmr_extend, tmr_yellow); end
    tick();
    checks++; if (phase !== 3'd0) begin errors++; $display("FAIL reset_hold_init: got %0d expected 0", phase); end
    rst_n = 1'b1;
    tick();
    checks++; if (phase !== 3'd1) begin errors++; $display("FAIL release_phase: got %0d expected 1", phase); end
    checks++; if (ns_light !== 2'b10 || ew_light !== 2'b00) begin errors++; $display("FAIL release_lamps: got ns=%b ew=%b expected 10/00", ns_light, ew_light); end
    checks++; if (tmr_start !== 1'b1 || tmr_extend !== 1'b0) begin errors++; $display("FAIL release_timer: got start=%b ext=%b expected 1/0", tmr_start, tmr_extend); end
  endtask

  task automatic test_extend();
    restart(1'b1, 1'b0);
    checks++; if (tmr_extend !== 1'b1) begin errors++; $display("FAIL extend_entry: got %b expected 1", tmr_extend); end
    ns_sensor = 1'b0;
    tick();
    checks++; if (tmr_extend !== 1'b1 || phase !== 3'd1) begin errors++; $display("FAIL extend_held: got ext=%b phase=%0d expected 1/1", tmr_extend, phase); end
    ew_sensor = 1'b1;
    expire();
    checks++; if (phase !== 3'd2) begin errors++; $display("FAIL extend_to_yellow_phase: got %0d expected 2", phase); end
    checks++; if (ns_light !== 2'b01 || ew_light !== 2'b00) begin errors++; $display("FAIL extend_yellow_lamps: got ns=%b ew=%b expected 01/00", ns_light, ew_light); end
    checks++; if (tmr_yellow !== 1'b1 || tmr_extend !== 1'b0) begin errors++; $display("FAIL extend_yellow_sel: got yel=%b ext=%b expected 1/0", tmr_yellow, tmr_extend); end
  endtask

  task automatic test_hold();
    logic [2:0] exp_hold [0:2];
    logic       exp_ext  [0:2];
    exp_hold[0] = 3'd1; exp_hold[1] = 3'd2; exp_hold[2] = 3'd3;
    exp_ext[0]  = 1'b0; exp_ext[1]  = 1'b1; exp_ext[2]  = 1'b1;
    restart(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      ns_sensor = (i != 0);
      expire();
      checks++; if (phase !== 3'd1) begin errors++; $display("FAIL hold_rearm_phase[%0d]: got %0d expected 1", i, phase); end
      checks++; if (dut.hold_cnt !== exp_hold[i]) begin errors++; $display("FAIL hold_cnt[%0d]: got %0d expected %0d", i, dut.hold_cnt, exp_hold[i]); end
      checks++; if (tmr_extend !== exp_ext[i] || tmr_start !== 1'b1) begin errors++; $display("FAIL hold_rearm_timer[%0d]: got ext=%b start=%b expected %b/1", i, tmr_extend, tmr_start, exp_ext[i]); end
    end
    expire();
    checks++; if (phase !== 3'd2) begin errors++; $display("FAIL hold_limit_phase: got %0d expected 2", phase); end
    checks++; if (dut.hold_cnt !== 3'd0) begin errors++; $display("FAIL hold_limit_clear: got %0d expected 0", dut.hold_cnt); end
    ns_sensor = 1'b0;
  endtask

  task automatic test_cycle();
    logic [2:0] exp_phase [0:3];
    logic [1:0] exp_ns    [0:3];
    logic [1:0] exp_ew    [0:3];
    exp_phase[0] = 3'd2; exp_ns[0] = 2'b01; exp_ew[0] = 2'b00;
    exp_phase[1] = 3'd3; exp_ns[1] = 2'b00; exp_ew[1] = 2'b10;
    exp_phase[2] = 3'd4; exp_ns[2] = 2'b00; exp_ew[2] = 2'b01;
    exp_phase[3] = 3'd1; exp_ns[3] = 2'b10; exp_ew[3] = 2'b00;
    restart(1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (phase !== ((i == 0) ? 3'd1 : exp_phase[i-1])) begin errors++; $display("FAIL cycle_idle_hold[%0d]: got %0d", i, phase); end
      expire();
      checks++; if (phase !== exp_phase[i]) begin errors++; $display("FAIL cycle_phase[%0d]: got %0d expected %0d", i, phase, exp_phase[i]); end
      checks++; if (ns_light !== exp_ns[i] || ew_light !== exp_ew[i]) begin errors++; $display("FAIL cycle_lamps[%0d]: got ns=%b ew=%b expected %b/%b", i, ns_light, ew_light, exp_ns[i], exp_ew[i]); end
      checks++; if (ns_light !== 2'b00 && ew_light !== 2'b00) begin errors++; $display("FAIL cycle_conflict[%0d]: got ns=%b ew=%b both non-red", i, ns_light, ew_light); end
    end
  endtask

  task automatic test_mid_reset();
    restart(1'b1, 1'b1);
    expire();
    expire();
    expire();
    checks++; if (phase !== 3'd4) begin errors++; $display("FAIL midrst_setup: got %0d expected 4", phase); end
    rst_n = 1'b0;
    #1;
    checks++; if (phase !== 3'd0) begin errors++; $display("FAIL midrst_phase: got %0d expected 0", phase); end
    checks++; if (ns_light !== 2'b00 || ew_light !== 2'b00) begin errors++; $display("FAIL midrst_lamps: got ns=%b ew=%b expected 00/00", ns_light, ew_light); end
    checks++; if (tmr_start !== 1'b0 || tmr_yellow !== 1'b0) begin errors++; $display("FAIL midrst_timer: got start=%b yel=%b expected 0/0", tmr_start, tmr_yellow); end
    tick();
    rst_n = 1'b1;
    tick();
    checks++; if (phase !== 3'd1 || tmr_start !== 1'b1) begin errors++; $display("FAIL midrst_release: got phase=%0d start=%b expected 1/1", phase, tmr_start); end
  endtask

`ifdef PED_REQUEST_EN
  task automatic test_ped();
    restart(1'b0, 1'b0);
    ped_req = 1'b1;
    tick();
    ped_req = 1'b0;
    expire();
    checks++; if (phase !== 3'd2) begin errors++; $display("FAIL ped_blocks_rearm: got %0d expected 2", phase); end
    expire();
    checks++; if (phase !== 3'd5 || ped_walk !== 1'b1) begin errors++; $display("FAIL ped_walk_entry: got phase=%0d walk=%b expected 5/1", phase, ped_walk); end
    checks++; if (ns_light !== 2'b00 || ew_light !== 2'b00) begin errors++; $display("FAIL ped_walk_lamps: got ns=%b ew=%b expected 00/00", ns_light, ew_light); end
    checks++; if (tmr_extend !== 1'b0 || tmr_yellow !== 1'b0 || tmr_start !== 1'b1) begin errors++; $display("FAIL ped_walk_timer: got ext=%b yel=%b start=%b expected 0/0/1", tmr_extend, tmr_yellow, tmr_start); end
    ped_req = 1'b1;
    tick();
    ped_req = 1'b0;
    ns_sensor = 1'b1;
    expire();
    checks++; if (phase !== 3'd3 || ped_walk !== 1'b0) begin errors++; $display("FAIL ped_exit: got phase=%0d walk=%b expected 3/0", phase, ped_walk); end
    expire();
    expire();
    checks++; if (phase !== 3'd1) begin errors++; $display("FAIL ped_dropped: got %0d expected 1", phase); end
    ns_sensor = 1'b0;
  endtask
`endif

  initial begin
    rst_n       = 1'b0;
    ns_sensor   = 1'b0;
    ew_sensor   = 1'b0;
    tmr_expired = 1'b0;
`ifdef PED_REQUEST_EN
    ped_req     = 1'b0;
`endif
    test_reset();
    test_extend();
    test_hold();
    test_cycle();
    test_mid_reset();
`ifdef PED_REQUEST_EN
    test_ped();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/traffic_phase_controller.md
TRAFFIC_PHASE_CONTROLLER -- requirements
Module: traffic_phase_controller

Interface
REQ-001 SHALL have parameter MAX_HOLD, default 3, max consecutive green re-arms when the cross road is idle (0..7).
REQ-002 SHALL have port clk  input  1  system clock, all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port ns_sensor  input  1  vehicle present on north-south road.
REQ-005 SHALL have port ew_sensor  input  1  vehicle present on east-west road.
REQ-006 SHALL have port tmr_expired  input  1  one-cycle expiry pulse from phase timer.
REQ-007 SHALL have port tmr_start  output  1  timer run enable; low clears the timer.
REQ-008 SHALL have port tmr_extend  output  1  select extended green duration.
REQ-009 SHALL have port tmr_yellow  output  1  select yellow duration.
REQ-010 SHALL have ports ns_light and ew_light  output  2 each  lamp code: 00 red, 01 yellow, 10 green, 11 never driven.
REQ-011 SHALL have port phase  output  3  current state code: INIT 0, NS_GREEN 1, NS_YELLOW 2, EW_GREEN 3, EW_YELLOW 4, PED_WALK 5.

Function
REQ-012 SHALL be a Moore FSM; all outputs registered, updated on the same edge as the state.
REQ-013 SHALL leave INIT for NS_GREEN on the first clock edge after reset release, unconditionally.
REQ-014 SHALL drive tmr_start=0 in INIT and tmr_start=1 in every other state, with no gap at phase changes.
REQ-015 SHALL ignore tmr_expired in INIT; in other states act only on cycles where tmr_expired=1.
REQ-016 SHALL drive tmr_yellow=1 only in NS_YELLOW and EW_YELLOW.
REQ-017 SHALL set tmr_extend on green entry or re-arm to (own-road sensor & ~cross-road sensor), held constant until the next green entry or re-arm, and 0 outside green.
REQ-018 SHALL on green expiry re-arm the same green if the cross sensor is 0, hold_cnt < MAX_HOLD and no pedestrian request is pending, incrementing hold_cnt.
REQ-019 SHALL otherwise move green to its yellow on expiry and clear hold_cnt.
REQ-020 SHALL move NS_YELLOW to EW_GREEN and EW_YELLOW to NS_GREEN on expiry, except as REQ-029.
REQ-021 SHALL sample sensors in the tmr_expired cycle only.
REQ-022 SHALL drive lamps: own road 10 in green, 01 in yellow, 00 otherwise; never both roads non-red.
REQ-023 SHALL saturate hold_cnt (3 bits) and never wrap; MAX_HOLD=0 disables re-arm.

Reset
REQ-024 SHALL on rst_n=0 immediately force state INIT, phase=0, ns_light=ew_light=00, tmr_start=tmr_extend=tmr_yellow=0, hold_cnt=0, ped latch=0, ped_walk=0.
REQ-025 SHALL apply REQ-024 mid-phase, dropping tmr_start so the external timer clears.

Configuration
REQ-026 SHALL compile pedestrian support only when macro PED_REQUEST_EN is defined.
REQ-027 With PED_REQUEST_EN SHALL add ports ped_req input 1 (request level) and ped_walk output 1 (walk lamp).
REQ-028 With PED_REQUEST_EN SHALL latch ped_req=1 in any state except PED_WALK; requests during PED_WALK are dropped.
REQ-029 With PED_REQUEST_EN SHALL go yellow-expiry to PED_WALK when latched, clearing the latch on entry; PED_WALK has both lamps 00, ped_walk=1, tmr_extend=0, tmr_yellow=0, and on expiry goes to the green REQ-020 would have chosen.
REQ-030 Without PED_REQUEST_EN SHALL have no ped ports, no PED_WALK state, and the REQ-018 pending term reads 0.

Verification
REQ-031 Reset release, sensors 0 -> cycle 1: phase=1, ns_light=10, tmr_start=1, tmr_extend=0.
REQ-032 ns_sensor=1, ew_sensor=0 at NS_GREEN entry -> tmr_extend=1; ew_sensor=1 at expiry -> phase 2, ns_light=01, tmr_yellow=1, tmr_extend=0.
REQ-033 MAX_HOLD=3, ew_sensor=0, four NS_GREEN expiries -> three re-arms in phase 1, fourth goes to phase 2, hold_cnt=0.
REQ-034 ew_sensor=1, pulse tmr_expired in phases 1,2,3,4 -> sequence 2,3,4,1; lamps never both non-00.
REQ-035 PED_REQUEST_EN, ped_req pulse during NS_GREEN -> after NS_YELLOW expiry phase=5, ped_walk=1, both lamps 00; next expiry phase=3.
REQ-036 rst_n low in EW_YELLOW -> same cycle phase=0, all lamps 00, tmr_start=0; release -> phase=1 next edge.
